boot_load_ctrl: RTL and testbench

Sequencer that turns the UART byte stream into memory writes while the core is held off. Each frame selects a destination (instruction memory, data memory or image buffer), a base address and a unit count. Payload bytes are packed into 32-bit words or 3072-bit image lines, and each completed unit gets a single write strobe. A final start command releases the CPU. The block sits between the UART receiver and the three memory write ports, and drives the CPU hold line.

---
 rtl/boot_load_ctrl_pkg.sv | 32 +++
 rtl/boot_load_ctrl_if.sv | 39 +++
 rtl/boot_load_ctrl_packer.sv | 36 +++
 rtl/boot_load_ctrl.sv | 133 +++++++++++++
 tb/tb_boot_load_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_load_ctrl_pkg.sv
// Shared types and constants for the UART boot loader: sequencer states,
// destination command codes and per-destination unit sizes.
package boot_load_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD,
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        DATA,
        RUN
    } boot_state_t;

    typedef enum logic [7:0] {
        IMAGE_BUFFER = 8'h01,
        D_MEM        = 8'h02,
        I_MEM        = 8'h04
    } boot_dest_t;

    localparam logic [7:0] BOOT_START = 8'h80;

    localparam int unsigned BCNT_W = 9;

    localparam logic [BCNT_W-1:0] WORD_BYTES = 9'd4;
    localparam logic [BCNT_W-1:0] LINE_BYTES = 9'd384;

    function automatic logic [BCNT_W-1:0] unit_size(input boot_dest_t dest);
        return (dest == IMAGE_BUFFER) ? LINE_BYTES : WORD_BYTES;
    endfunction

endpackage

// File: rtl/boot_load_ctrl_if.sv
// Boot loader bus bundle: UART byte stream in, I/D memory and image buffer
// write ports plus CPU hold/status out.
interface boot_load_ctrl_if #(
    parameter int DATA_W  = 32,
    parameter int DMEM_AW = 13,
    parameter int IB_DW   = 3072,
    parameter int IB_AW   = 8
);

    logic               rx_vld;
    logic [7:0]         rx_data;
    logic               imem_we;
    logic               dmem_we;
    logic [DMEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               ib_we;
    logic [IB_AW-1:0]   ib_addr;
    logic [IB_DW-1:0]   ib_wdata;
    logic               cpu_hold;
    logic               boot_done;
    logic               cmd_err;

    // UART / memory side
    modport master (
        output rx_vld, rx_data,
        input  imem_we, dmem_we, mem_addr, mem_wdata,
        input  ib_we, ib_addr, ib_wdata,
        input  cpu_hold, boot_done, cmd_err
    );

    // Boot controller side
    modport slave (
        input  rx_vld, rx_data,
        output imem_we, dmem_we, mem_addr, mem_wdata,
        output ib_we, ib_addr, ib_wdata,
        output cpu_hold, boot_done, cmd_err
    );

endinterface

// File: rtl/boot_load_ctrl_packer.sv
// Byte-lane packer: byte k of a unit lands at bits [8k+7:8k]; unit_full flags
// the byte that completes the current unit.
module boot_byte_packer
    import boot_load_ctrl_pkg::*;
#(
    parameter int W = 3072
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_in,
    input  logic [BCNT_W-1:0] unit_bytes,
    output logic [W-1:0]      data,
    output logic              unit_full
);

    logic [BCNT_W-1:0] byte_cnt;

    assign unit_full = byte_vld && (byte_cnt == unit_bytes - 9'd1);

    // Lanes are overwritten in place rather than cleared, so a completed unit
    // stays on the outputs until the first byte of the next unit arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (byte_vld) begin
            data[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt <= unit_full ? '0 : byte_cnt + 9'd1;
        end
    end

endmodule

// File: rtl/boot_load_ctrl.sv
// UART boot sequencer: parses CMD/ADDR/LEN frames, packs payload into words or
// image lines, strobes one write per unit and releases the CPU on START.
module boot_load_ctrl
    import boot_load_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 11,
    parameter int DMEM_AW = 13,
    parameter int IB_DW   = 3072,
    parameter int IB_AW   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    boot_load_ctrl_if.slave bus
);

    boot_state_t       state;
    boot_dest_t        dest;
    logic [15:0]       base;
    logic [15:0]       len;
    logic [15:0]       unit_idx;

    logic              pk_vld;
    logic              pk_clr;
    logic              pk_full;
    logic [IB_DW-1:0]  pk_data;

    assign pk_vld = bus.rx_vld && (state == DATA);
    assign pk_clr = bus.rx_vld && (state == LEN_HI);

    boot_byte_packer #(
        .W (IB_DW)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pk_clr),
        .byte_vld   (pk_vld),
        .byte_in    (bus.rx_data),
        .unit_bytes (unit_size(dest)),
        .data       (pk_data),
        .unit_full  (pk_full)
    );

    // Word data shares the packer's low lanes; both data buses are registers.
    assign bus.mem_wdata = pk_data[DATA_W-1:0];
    assign bus.ib_wdata  = pk_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CMD;
            dest          <= D_MEM;
            base          <= '0;
            len           <= '0;
            unit_idx      <= '0;
            bus.imem_we   <= 1'b0;
            bus.dmem_we   <= 1'b0;
            bus.ib_we     <= 1'b0;
            bus.mem_addr  <= '0;
            bus.ib_addr   <= '0;
            bus.cpu_hold  <= 1'b1;
            bus.boot_done <= 1'b0;
            bus.cmd_err   <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            bus.dmem_we <= 1'b0;
            bus.ib_we   <= 1'b0;

            if (bus.rx_vld) begin
                case (state)
                    CMD: begin
                        case (bus.rx_data)
                            I_MEM, D_MEM, IMAGE_BUFFER: begin
                                dest  <= boot_dest_t'(bus.rx_data);
                                state <= ADDR_LO;
                            end
                            BOOT_START: begin
                                state         <= RUN;
                                bus.cpu_hold  <= 1'b0;
                                bus.boot_done <= 1'b1;
                            end
                            default: bus.cmd_err <= 1'b1;
                        endcase
                    end
                    ADDR_LO: begin
                        base[7:0] <= bus.rx_data;
                        state     <= ADDR_HI;
                    end
                    ADDR_HI: begin
                        base[15:8] <= bus.rx_data;
                        state      <= LEN_LO;
                    end
                    LEN_LO: begin
                        len[7:0] <= bus.rx_data;
                        state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        len[15:8] <= bus.rx_data;
                        unit_idx  <= '0;
                        state     <= ({bus.rx_data, len[7:0]} == 16'd0) ? CMD : DATA;
                    end
                    DATA: begin
                        if (pk_full) begin
                            // Addresses wrap modulo the destination port width.
                            unique case (dest)
                                I_MEM: begin
                                    bus.imem_we  <= 1'b1;
                                    bus.mem_addr <= DMEM_AW'(IMEM_AW'(base + unit_idx));
                                end
                                D_MEM: begin
                                    bus.dmem_we  <= 1'b1;
                                    bus.mem_addr <= DMEM_AW'(base + unit_idx);
                                end
                                IMAGE_BUFFER: begin
                                    bus.ib_we   <= 1'b1;
                                    bus.ib_addr <= IB_AW'(base + unit_idx);
                                end
                            endcase
                            unit_idx <= unit_idx + 16'd1;
                            if (unit_idx + 16'd1 == len) begin
                                state <= CMD;
                            end
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: state <= CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl: frame-level reference model predicts
// every write (kind, address, data, cycle); a monitor matches strobes to it.
module tb_boot_load_ctrl;

    localparam int DATA_W  = 32;
    localparam int IMEM_AW = 11;
    localparam int DMEM_AW = 13;
    localparam int IB_DW   = 3072;
    localparam int IB_AW   = 8;

    typedef struct {
        int               kind;   // 0 imem, 1 dmem, 2 image buffer
        int unsigned      addr;
        logic [IB_DW-1:0] data;
        longint           due;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    boot_load_ctrl_if #(
        .DATA_W  (DATA_W),
        .DMEM_AW (DMEM_AW),
        .IB_DW   (IB_DW),
        .IB_AW   (IB_AW)
    ) bus ();

    boot_load_ctrl #(
        .DATA_W  (DATA_W),
        .IMEM_AW (IMEM_AW),
        .DMEM_AW (DMEM_AW),
        .IB_DW   (IB_DW),
        .IB_AW   (IB_AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;
    int unsigned n_strobes = 0;
    int unsigned n_pushed  = 0;
    longint      cycle     = 0;
    bit          booted    = 1'b0;
    wr_t         exp_q[$];
    logic [7:0]  pay[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n) begin
            int  ns;
            int  kind;
            wr_t e;
            ns = int'(bus.imem_we) + int'(bus.dmem_we) + int'(bus.ib_we);
            while (exp_q.size() != 0 && exp_q[0].due < cycle) begin
                check("missed_we_due", cycle, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (ns != 0) begin
                n_strobes++;
                check("we_exclusive", ns, 1);
                if (exp_q.size() == 0) begin
                    check("spurious_we", n_strobes, n_pushed);
                end else begin
                    e = exp_q.pop_front();
                    kind = bus.imem_we ? 0 : (bus.dmem_we ? 1 : 2);
                    check("we_kind", kind, e.kind);
                    check("we_cycle", cycle, e.due);
                    if (kind == 2) begin
                        check("ib_addr", bus.ib_addr, e.addr);
                        for (int i = 0; i < IB_DW / 64; i++)
                            check($sformatf("ib_data[%0d]", i), bus.ib_wdata[64*i +: 64], e.data[64*i +: 64]);
                    end else if (kind == 0) begin
                        check("imem_addr", bus.mem_addr[IMEM_AW-1:0], e.addr);
                        check("imem_data", bus.mem_wdata, e.data[31:0]);
                    end else begin
                        check("dmem_addr", bus.mem_addr, e.addr);
                        check("dmem_data", bus.mem_wdata, e.data[31:0]);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit push, input wr_t e);
        wr_t x;
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        if (push) begin
            x     = e;
            x.due = cycle + 1;
            exp_q.push_back(x);
            n_pushed++;
        end
        @(negedge clk);
        bus.rx_vld = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
    endtask

    // Reference model: a frame of len units produces one write per completed
    // unit at (addr + unit) mod 2^port_width, bytes packed LSB first.
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] len);
        wr_t              none;
        wr_t              e;
        bit               writes;
        int unsigned      unit;
        int unsigned      modulo;
        int               kind;
        logic [IB_DW-1:0] cur;
        none   = '{kind: 0, addr: 0, data: '0, due: 0};
        writes = !booted && (cmd == 8'h04 || cmd == 8'h02 || cmd == 8'h01);
        unit   = (cmd == 8'h01) ? 384 : 4;
        kind   = (cmd == 8'h04) ? 0 : ((cmd == 8'h02) ? 1 : 2);
        modulo = (kind == 0) ? 2048 : ((kind == 1) ? 8192 : 256);
        send_byte(cmd, 1'b0, none);
        send_byte(addr[7:0], 1'b0, none);
        send_byte(addr[15:8], 1'b0, none);
        send_byte(len[7:0], 1'b0, none);
        send_byte(len[15:8], 1'b0, none);
        cur = '0;
        for (int i = 0; i < pay.size(); i++) begin
            int unsigned u;
            u = int'(i) / unit;
            cur[8*(int'(i) % unit) +: 8] = pay[i];
            e.kind = kind;
            e.addr = (int'(addr) + u) % modulo;
            e.data = cur;
            e.due  = 0;
            send_byte(pay[i], writes && ((i + 1) % unit == 0) && (u < len), e);
        end
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_hold"}, bus.cpu_hold, 1);
        check({tag, "_boot_done"}, bus.boot_done, 0);
        check({tag, "_cmd_err"}, bus.cmd_err, 0);
        check({tag, "_strobes"}, {bus.imem_we, bus.dmem_we, bus.ib_we}, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_ib_addr"}, bus.ib_addr, 0);
        check({tag, "_ib_wdata_any"}, |bus.ib_wdata, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t         none;
        int unsigned s0;
        int          n_ib;
        none = '{kind: 0, addr: 0, data: '0, due: 0};
        bus.rx_vld  = 1'b0;
        bus.rx_data = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // D_MEM 0x10, two words
        pay = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(8'h02, 16'h0010, 16'd2);

        // I_MEM wrap at the top of the 11-bit space
        fill_random(8);
        send_frame(8'h04, 16'h07FF, 16'd2);

        // Image line 3, bytes = index mod 256
        pay.delete();
        for (int i = 0; i < 384; i++) pay.push_back(8'(i));
        send_frame(8'h01, 16'h0003, 16'd1);

        // D_MEM wrap past 0x1FFF from a 16-bit base
        fill_random(16);
        send_frame(8'h02, 16'hFFFE, 16'd4);

        // Randomized frames
        n_ib = 0;
        for (int f = 0; f < 16; f++) begin
            int unsigned r;
            logic [7:0]  cmd;
            logic [15:0] len;
            r   = $urandom_range(9, 0);
            cmd = (r < 4) ? 8'h04 : ((r < 8 || n_ib >= 2) ? 8'h02 : 8'h01);
            if (cmd == 8'h01) begin
                n_ib++;
                len = 16'd1;
                fill_random(384);
            end else begin
                len = 16'($urandom_range(5, 1));
                fill_random(4 * int'(len));
            end
            send_frame(cmd, 16'($urandom), len);
        end

        // Reset in the middle of a word: the partial word must never be written
        pay = '{8'hAA, 8'hBB};
        send_frame(8'h02, 16'h0020, 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(8'h02, 16'h0020, 16'd1);
        check("after_midrst_hold", bus.cpu_hold, 1);

        // Bad command, zero-length frame, then START
        s0 = n_strobes;
        send_byte(8'h55, 1'b0, none);
        check("bad_cmd_err", bus.cmd_err, 1);
        pay.delete();
        send_frame(8'h02, 16'h0040, 16'd0);
        check("len0_no_strobe", n_strobes - s0, 0);
        @(negedge clk);
        bus.rx_data = 8'h80;
        bus.rx_vld  = 1'b1;
        check("start_hold_before", bus.cpu_hold, 1);
        @(negedge clk);
        bus.rx_vld = 1'b0;
        check("start_hold_fall", bus.cpu_hold, 0);
        check("start_boot_done", bus.boot_done, 1);
        booted = 1'b1;
        repeat (2) @(negedge clk);

        // Everything after START is ignored
        s0 = n_strobes;
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(8'h02, 16'h0000, 16'd1);
        check("run_no_strobe", n_strobes - s0, 0);
        check("run_hold", bus.cpu_hold, 0);
        check("run_boot_done", bus.boot_done, 1);
        check("run_cmd_err", bus.cmd_err, 1);

        repeat (4) @(negedge clk);
        check("pending_writes", exp_q.size(), 0);
        check("strobe_total", n_strobes, n_pushed);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
